// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: opcodes, FSM states and the single-cycle result function shared by alu_mc.
// Build option ALU_MC_DIV_EN (enables DIVU) is handled in alu_mc and alu_mc_iter.
package alu_mc_pkg;

  localparam int OPC_W = 6;
  localparam int MAX_W = 64;

  localparam logic [OPC_W-1:0] OP_NOP  = 6'h00;
  localparam logic [OPC_W-1:0] OP_ADD  = 6'h20;
  localparam logic [OPC_W-1:0] OP_SUB  = 6'h02;
  localparam logic [OPC_W-1:0] OP_AND  = 6'h03;
  localparam logic [OPC_W-1:0] OP_OR   = 6'h04;
  localparam logic [OPC_W-1:0] OP_XOR  = 6'h05;
  localparam logic [OPC_W-1:0] OP_NOR  = 6'h06;
  localparam logic [OPC_W-1:0] OP_SLT  = 6'h07;
  localparam logic [OPC_W-1:0] OP_SLTU = 6'h08;
  localparam logic [OPC_W-1:0] OP_SLL  = 6'h09;
  localparam logic [OPC_W-1:0] OP_SRL  = 6'h0A;
  localparam logic [OPC_W-1:0] OP_SRA  = 6'h0B;
  localparam logic [OPC_W-1:0] OP_MULU = 6'h10;
  localparam logic [OPC_W-1:0] OP_DIVU = 6'h11;
  localparam logic [OPC_W-1:0] OP_DEC  = 6'h3F;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Operands arrive zero-extended to MAX_W; w is the live datapath width, the caller keeps the low w bits.
  function automatic logic [MAX_W-1:0] alu_single(input logic [OPC_W-1:0] op,
                                                  input logic [MAX_W-1:0] a,
                                                  input logic [MAX_W-1:0] b,
                                                  input int w,
                                                  output logic known);
    logic [MAX_W-1:0] sa, sb, r;
    logic [5:0] sh;
    for (int i = 0; i < MAX_W; i++) begin
      sa[i] = (i < w) ? a[i] : a[w-1];
      sb[i] = (i < w) ? b[i] : b[w-1];
    end
    sh = b[5:0] & 6'(w - 1);
    known = 1'b1;
    case (op)
      OP_NOP:  r = '0;
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_SLT:  r = MAX_W'($signed(sa) < $signed(sb));
      OP_SLTU: r = MAX_W'(a < b);
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = $signed(sa) >>> sh;
      OP_DEC:  r = a - MAX_W'(1);
      default: begin
        r = '0;
        known = 1'b0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: one-bit-per-cycle shift-add multiplier and (with ALU_MC_DIV_EN) restoring divider.
// hi/lo present the post-step values so the caller can register them on the last step.
module alu_mc_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt;
  logic             div_r;
  logic [WIDTH-1:0] opb, lo_r, lo_nxt;
  logic [WIDTH:0]   sum;
`ifdef ALU_MC_DIV_EN
  logic [WIDTH:0]   hi_r, hi_nxt;
  logic [WIDTH+1:0] sh, diff;
`else
  logic [WIDTH-1:0] hi_r, hi_nxt;
`endif

  always_comb begin
    sum    = {1'b0, hi_r[WIDTH-1:0]} + (lo_r[0] ? {1'b0, opb} : '0);
    lo_nxt = {sum[0], lo_r[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
    hi_nxt = {1'b0, sum[WIDTH:1]};
    sh     = {hi_r, lo_r[WIDTH-1]};
    diff   = sh - {2'b00, opb};
    if (div_r) begin
      // negative trial difference means restore (keep the shifted remainder)
      hi_nxt = diff[WIDTH+1] ? sh[WIDTH:0] : diff[WIDTH:0];
      lo_nxt = {lo_r[WIDTH-2:0], ~diff[WIDTH+1]};
    end
`else
    hi_nxt = sum[WIDTH:1];
`endif
  end

`ifdef ALU_MC_DIV_EN
  assign hi = hi_nxt[WIDTH-1:0];
  assign lo = lo_nxt;
`else
  assign hi = div_r ? '0 : hi_nxt;
  assign lo = div_r ? '0 : lo_nxt;
`endif

  assign last = en && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      div_r <= 1'b0;
      opb   <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
    end else if (load) begin
      cnt   <= CW'(WIDTH - 1);
      div_r <= mode;
      opb   <= b;
      hi_r  <= '0;
      lo_r  <= a;
    end else if (en) begin
      cnt   <= cnt - CW'(1);
      hi_r  <= hi_nxt;
      lo_r  <= lo_nxt;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multicycle ALU with start/busy/done handshake; results registered and held until the next start.
// Build option ALU_MC_DIV_EN adds unsigned divide; without it DIVU reports err.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_out_hi,
  output logic             zero,
  output logic             ovf,
  output logic             dz,
  output logic             err
);

  state_t           state, state_nxt;
  logic             op_ok, is_mul, is_div, iter_op, accept, load, en, last, known;
  logic [OPC_W-1:0] op6;
  logic [WIDTH-1:0] sc_out, sc_hi, it_hi, it_lo;
  logic             sc_ovf, sc_dz, sc_err;

  always_comb begin
    op_ok  = ((alu_op >> OPC_W) == '0);
    op6    = alu_op[OPC_W-1:0];
    is_mul = op_ok && (op6 == OP_MULU);
`ifdef ALU_MC_DIV_EN
    is_div  = op_ok && (op6 == OP_DIVU);
    iter_op = is_mul || (is_div && (alu_b != '0));
`else
    is_div  = 1'b0;
    iter_op = is_mul;
`endif
  end

  always_comb begin
    sc_out = WIDTH'(alu_single(op6, MAX_W'(alu_a), MAX_W'(alu_b), WIDTH, known));
    sc_hi  = '0;
    sc_dz  = 1'b0;
    sc_err = !(known && op_ok);
    sc_ovf = 1'b0;
    if (sc_err) sc_out = '0;
    if (op_ok && op6 == OP_ADD)
      sc_ovf = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sc_out[WIDTH-1] != alu_a[WIDTH-1]);
    if (op_ok && op6 == OP_SUB)
      sc_ovf = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (sc_out[WIDTH-1] != alu_a[WIDTH-1]);
    if (is_div && alu_b == '0) begin
      sc_out = '1;
      sc_hi  = alu_a;
      sc_dz  = 1'b1;
      sc_err = 1'b0;
    end
  end

  always_comb begin
    accept    = start && (state != RUN);
    state_nxt = state;
    load      = 1'b0;
    en        = 1'b0;
    case (state)
      RUN: begin
        en = 1'b1;
        if (last) state_nxt = DONE;
      end
      default: begin
        state_nxt = IDLE;
        if (accept) begin
          if (iter_op) begin
            load      = 1'b1;
            state_nxt = RUN;
          end else begin
            state_nxt = DONE;
          end
        end
      end
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .en   (en),
    .mode (is_div),
    .a    (alu_a),
    .b    (alu_b),
    .hi   (it_hi),
    .lo   (it_lo),
    .last (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_out    <= '0;
      alu_out_hi <= '0;
      zero       <= 1'b0;
      ovf        <= 1'b0;
      dz         <= 1'b0;
      err        <= 1'b0;
    end else if (accept && !iter_op) begin
      alu_out    <= sc_out;
      alu_out_hi <= sc_hi;
      zero       <= (sc_out == '0);
      ovf        <= sc_ovf;
      dz         <= sc_dz;
      err        <= sc_err;
    end else if (last) begin
      alu_out    <= it_lo;
      alu_out_hi <= it_hi;
      zero       <= (it_lo == '0);
      ovf        <= 1'b0;
      dz         <= 1'b0;
      err        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc (WIDTH=32); DIVU expectations follow ALU_MC_DIV_EN.
module tb_alu_mc;
  import alu_mc_pkg::*;

  logic        clk, rst, start;
  logic [5:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic        busy, done, zero, ovf, dz, err;
  logic [31:0] alu_out, alu_out_hi;

  int checks = 0;
  int failures = 0;

  alu_mc #(.WIDTH(32), .OP_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .busy(busy), .done(done), .alu_out(alu_out), .alu_out_hi(alu_out_hi),
    .zero(zero), .ovf(ovf), .dz(dz), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        v;
  } vec_t;

  // Drive one start pulse; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; alu_op = op; alu_a = a; alu_b = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; alu_op = '0; alu_a = '0; alu_b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL reset_busy_done got=%b exp=00", {busy, done}); end
    checks++; if (alu_out !== 32'h0 || alu_out_hi !== 32'h0) begin failures++; $display("FAIL reset_out got=%h_%h exp=0_0", alu_out_hi, alu_out); end
    checks++; if ({zero, ovf, dz, err} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {zero, ovf, dz, err}); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_add_ovf();
    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL add_done got=%b exp=1", done); end
    checks++; if (alu_out !== 32'h8000_0000) begin failures++; $display("FAIL add_out got=%h exp=80000000", alu_out); end
    checks++; if ({ovf, zero, err, alu_out_hi} !== {3'b100, 32'h0}) begin failures++; $display("FAIL add_flags got=%b%b%b hi=%h exp=100 hi=0", ovf, zero, err, alu_out_hi); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || alu_out !== 32'h8000_0000 || ovf !== 1'b1) begin failures++; $display("FAIL add_hold got=done%b out=%h ovf=%b exp=done0 out=80000000 ovf1", done, alu_out, ovf); end
  endtask

  task automatic test_single_ops();
    vec_t v[13];
    v[0]  = '{OP_AND,  32'hFFFF_0000, 32'h0FF0_0FF0, 32'h0FF0_0000, 1'b0};
    v[1]  = '{OP_OR,   32'h0000_F0F0, 32'h0F0F_0000, 32'h0F0F_F0F0, 1'b0};
    v[2]  = '{OP_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0};
    v[3]  = '{OP_NOR,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
    v[4]  = '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
    v[5]  = '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
    v[6]  = '{OP_SLL,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0};
    v[7]  = '{OP_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0};
    v[8]  = '{OP_SRA,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0};
    v[9]  = '{OP_DEC,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
    v[10] = '{OP_NOP,  32'h0000_1234, 32'h0000_5678, 32'h0000_0000, 1'b0};
    v[11] = '{OP_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0};
    v[12] = '{OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1};
    for (int i = 0; i < 13; i++) begin
      issue(v[i].op, v[i].a, v[i].b);
      checks++;
      if (done !== 1'b1 || alu_out !== v[i].r || alu_out_hi !== 32'h0 || ovf !== v[i].v ||
          zero !== (v[i].r == 32'h0) || err !== 1'b0 || dz !== 1'b0) begin
        failures++;
        $display("FAIL vec%0d op=%h got=done%b out=%h hi=%h ovf%b z%b err%b exp=done1 out=%h hi=0 ovf%b z%b err0",
                 i, v[i].op, done, alu_out, alu_out_hi, ovf, zero, err, v[i].r, v[i].v, v[i].r == 32'h0);
      end
    end
    issue(OP_SUB, 32'h0, 32'h1);
    checks++; if (alu_out !== 32'hFFFF_FFFF || ovf !== 1'b0) begin failures++; $display("FAIL sub_neg got=%h ovf%b exp=ffffffff ovf0", alu_out, ovf); end
  endtask

  task automatic test_err();
    issue(6'h1F, 32'h1234_5678, 32'h1);
    checks++; if (done !== 1'b1 || err !== 1'b1 || alu_out !== 32'h0 || alu_out_hi !== 32'h0) begin failures++; $display("FAIL bad_op got=done%b err%b out=%h hi=%h exp=done1 err1 out=0 hi=0", done, err, alu_out, alu_out_hi); end
  endtask

  task automatic test_mulu();
    int n;
    logic held;
    logic [31:0] prev;
    prev = alu_out;
    held = 1'b1;
    issue(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (alu_out !== prev || done !== 1'b0) held = 1'b0;
      if (n == 5) begin
        start = 1'b1; alu_op = OP_ADD; alu_a = 32'h1; alu_b = 32'h1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++; if (n !== 32) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=32", n); end
    checks++; if (held !== 1'b1) begin failures++; $display("FAIL mul_hold got=%b exp=1", held); end
    checks++; if (done !== 1'b1 || alu_out_hi !== 32'hFFFF_FFFE || alu_out !== 32'h0000_0001 || err !== 1'b0) begin failures++; $display("FAIL mul_max got=done%b %h_%h err%b exp=done1 fffffffe_00000001 err0", done, alu_out_hi, alu_out, err); end
    issue(OP_MULU, 32'h1234_5678, 32'h0000_0010);
    n = 0;
    while (!done && n < 40) begin n++; @(posedge clk); #1; end
    checks++; if (n !== 32 || alu_out_hi !== 32'h1 || alu_out !== 32'h2345_6780) begin failures++; $display("FAIL mul_small got=wait%0d %h_%h exp=wait32 00000001_23456780", n, alu_out_hi, alu_out); end
  endtask

  task automatic test_divu();
    int n;
`ifdef ALU_MC_DIV_EN
    issue(OP_DIVU, 32'd100, 32'd7);
    n = 0;
    while (!done && n < 40) begin n++; @(posedge clk); #1; end
    checks++; if (n !== 32 || alu_out !== 32'd14 || alu_out_hi !== 32'd2 || dz !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL div_100_7 got=wait%0d q=%0d r=%0d dz%b err%b exp=wait32 q=14 r=2 dz0 err0", n, alu_out, alu_out_hi, dz, err); end
    issue(OP_DIVU, 32'd5, 32'd0);
    checks++; if (done !== 1'b1 || alu_out !== 32'hFFFF_FFFF || alu_out_hi !== 32'd5 || dz !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL div_zero got=done%b %h_%h dz%b err%b exp=done1 00000005_ffffffff dz1 err0", done, alu_out_hi, alu_out, dz, err); end
`else
    issue(OP_DIVU, 32'd100, 32'd7);
    n = 0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b1 || alu_out !== 32'h0 || alu_out_hi !== 32'h0 || dz !== 1'b0) begin failures++; $display("FAIL div_off got=done%b busy%b err%b %h_%h dz%b exp=done1 busy0 err1 0_0 dz0", done, busy, err, alu_out_hi, alu_out, dz); end
    issue(OP_DIVU, 32'd5, 32'd0);
    checks++; if (done !== 1'b1 || err !== 1'b1 || alu_out !== 32'h0 || dz !== 1'b0) begin failures++; $display("FAIL div_off_zero got=done%b err%b out=%h dz%b exp=done1 err1 out=0 dz0", done, err, alu_out, dz); end
    if (n != 0) $display("unexpected wait count %0d", n);
`endif
  endtask

  task automatic test_reset_mid();
    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1);
    issue(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL rst_mid_ctrl got=%b exp=00", {busy, done}); end
    checks++; if (alu_out !== 32'h0 || alu_out_hi !== 32'h0 || {zero, ovf, dz, err} !== 4'b0000) begin failures++; $display("FAIL rst_mid_out got=%h_%h flags=%b exp=0_0 flags=0000", alu_out_hi, alu_out, {zero, ovf, dz, err}); end
    @(negedge clk); rst = 1'b0;
    issue(OP_ADD, 32'd3, 32'd4);
    checks++; if (done !== 1'b1 || alu_out !== 32'd7) begin failures++; $display("FAIL rst_then_add got=done%b out=%h exp=done1 out=7", done, alu_out); end
  endtask

  task automatic test_back_to_back();
    issue(OP_SUB, 32'd9, 32'd4);
    checks++; if (done !== 1'b1 || alu_out !== 32'd5) begin failures++; $display("FAIL b2b_sub got=done%b out=%h exp=done1 out=5", done, alu_out); end
    start = 1'b1; alu_op = OP_ADD; alu_a = 32'd1; alu_b = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (done !== 1'b1 || alu_out !== 32'd2) begin failures++; $display("FAIL b2b_add got=done%b out=%h exp=done1 out=2", done, alu_out); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0 || alu_out !== 32'd2) begin failures++; $display("FAIL b2b_idle got=done%b busy%b out=%h exp=done0 busy0 out=2", done, busy, alu_out); end
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_single_ops();
    test_err();
    test_mulu();
    test_divu();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
